// File: rtl/matrix_vector_mac_stream.sv
// Streaming matrix-vector MAC: each accepted vector element updates every row sum in parallel.
// Weights sit in registers and may be rewritten at any time; a finished result is held until taken.
module matrix_vector_mac_stream #(
  parameter int data_width  = 2,
  parameter int n_columns   = 2,
  parameter int m_rows      = 2,
  parameter int signed_mode = 0,
  localparam int acc_w = 2*data_width + $clog2(n_columns) + 1,
  localparam int row_w = (m_rows > 1) ? $clog2(m_rows) : 1,
  localparam int col_w = (n_columns > 1) ? $clog2(n_columns) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      w_we,
  input  logic [row_w-1:0]          w_row,
  input  logic [col_w-1:0]          w_col,
  input  logic [data_width-1:0]     w_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [data_width-1:0]     in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [acc_w*m_rows-1:0]   outp
);

  // One-hot so that in_ready and out_valid are register bits directly.
  localparam logic [1:0] ST_ACC = 2'b01;
  localparam logic [1:0] ST_OUT = 2'b10;

  logic [1:0]            state_q, state_d;
  logic [col_w-1:0]      col_q, col_d;
  logic [acc_w-1:0]      acc_q [m_rows];
  logic [acc_w-1:0]      acc_d [m_rows];
  logic [data_width-1:0] w_q   [m_rows][n_columns];
  logic [data_width-1:0] w_sel_s [m_rows];
  logic                  last_col_s;

  function automatic logic [acc_w-1:0] extend(input logic [data_width-1:0] v);
    logic [acc_w-1:0] r;
    if (signed_mode != 0) r = {{(acc_w-data_width){v[data_width-1]}}, v};
    else                  r = {{(acc_w-data_width){1'b0}}, v};
    return r;
  endfunction

  assign last_col_s = (col_q == col_w'(n_columns - 1));

  // Weight register file; addresses outside the array match no entry and are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < m_rows; r++)
        for (int c = 0; c < n_columns; c++)
          w_q[r][c] <= {data_width{1'b0}};
    end else if (w_we) begin
      for (int r = 0; r < m_rows; r++)
        for (int c = 0; c < n_columns; c++)
          if (w_row == row_w'(r) && w_col == col_w'(c)) w_q[r][c] <= w_data;
    end
  end

  // Column select of the current weight per row.
  always_comb begin
    for (int r = 0; r < m_rows; r++) begin
      w_sel_s[r] = {data_width{1'b0}};
      for (int c = 0; c < n_columns; c++)
        if (col_q == col_w'(c)) w_sel_s[r] = w_q[r][c];
    end
  end

  // Accumulate / hand-off state machine.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    acc_d   = acc_q;
    case (state_q)
      ST_ACC: begin
        if (in_valid) begin
          for (int r = 0; r < m_rows; r++)
            acc_d[r] = acc_q[r] + extend(w_sel_s[r]) * extend(in_data);
          if (last_col_s) begin
            col_d   = {col_w{1'b0}};
            state_d = ST_OUT;
          end else begin
            col_d = col_q + col_w'(1);
          end
        end else begin
          state_d = ST_ACC;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          for (int r = 0; r < m_rows; r++) acc_d[r] = {acc_w{1'b0}};
          state_d = ST_ACC;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_ACC;
        col_d   = {col_w{1'b0}};
        for (int r = 0; r < m_rows; r++) acc_d[r] = {acc_w{1'b0}};
      end
    endcase
  end

  // State, column and accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACC;
      col_q   <= {col_w{1'b0}};
      for (int r = 0; r < m_rows; r++) acc_q[r] <= {acc_w{1'b0}};
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      for (int r = 0; r < m_rows; r++) acc_q[r] <= acc_d[r];
    end
  end

  assign in_ready  = state_q[0];
  assign out_valid = state_q[1];

  for (genvar g = 0; g < m_rows; g++) begin : g_outp
    assign outp[g*acc_w +: acc_w] = acc_q[g];
  end

endmodule

// File: tb/tb_matrix_vector_mac_stream.sv
// Bench for matrix_vector_mac_stream: one unsigned and one signed instance with default sizes,
// directed scenarios followed by random vectors checked against an integer dot-product model.
module tb_matrix_vector_mac_stream;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       w_we, w_row, w_col, in_valid, in_ready, out_valid, out_ready;
  logic [1:0][1:0]  w_data, in_data;
  logic [1:0][11:0] outp;
  int               wm [2][2][2];
  int               vectors = 0;
  int               miscompares = 0;

  always #5 clk = ~clk;

  matrix_vector_mac_stream #(.data_width(2), .n_columns(2), .m_rows(2), .signed_mode(0)) dut_u (
    .clk(clk), .rst(rst), .w_we(w_we[0]), .w_row(w_row[0]), .w_col(w_col[0]), .w_data(w_data[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .outp(outp[0]));

  matrix_vector_mac_stream #(.data_width(2), .n_columns(2), .m_rows(2), .signed_mode(1)) dut_s (
    .clk(clk), .rst(rst), .w_we(w_we[1]), .w_row(w_row[1]), .w_col(w_col[1]), .w_data(w_data[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .outp(outp[1]));

  function automatic int sval(input int k, input logic [1:0] v);
    return (k == 1) ? int'($signed(v)) : int'(v);
  endfunction

  // Expected packed outp after ncols elements of (x0, x1) have been accumulated.
  function automatic logic [11:0] expect_out(input int k, input logic [1:0] x0, input logic [1:0] x1,
                                             input int ncols);
    logic [11:0] e;
    int s;
    e = 12'd0;
    for (int r = 0; r < 2; r++) begin
      s = 0;
      if (ncols > 0) s += wm[k][r][0] * sval(k, x0);
      if (ncols > 1) s += wm[k][r][1] * sval(k, x1);
      e[r*6 +: 6] = 6'(s);
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_w(input int k, input int r, input int c, input logic [1:0] v);
    w_we[k] = 1'b1; w_row[k] = 1'(r); w_col[k] = 1'(c); w_data[k] = v;
    tick();
    w_we[k] = 1'b0;
    wm[k][r][c] = sval(k, v);
  endtask

  task automatic load(input int k, input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] c, input logic [1:0] d);
    write_w(k, 0, 0, a); write_w(k, 0, 1, b); write_w(k, 1, 0, c); write_w(k, 1, 1, d);
  endtask

  task automatic run_vec(input int k, input logic [1:0] x0, input logic [1:0] x1,
                         input int bubbles, input int hold, input string tag);
    logic [11:0] e1, ef;
    e1 = expect_out(k, x0, x1, 1);
    ef = expect_out(k, x0, x1, 2);
    out_ready[k] = (hold == 0);
    check($sformatf("%s/ready_pre", tag), 12'(in_ready[k]), 12'd1);
    in_valid[k] = 1'b1; in_data[k] = x0;
    tick();
    in_valid[k] = 1'b0;
    check($sformatf("%s/partial", tag), outp[k], e1);
    check($sformatf("%s/valid_early", tag), 12'(out_valid[k]), 12'd0);
    repeat (bubbles) tick();
    check($sformatf("%s/bubble_hold", tag), outp[k], e1);
    in_valid[k] = 1'b1; in_data[k] = x1;
    tick();
    in_valid[k] = 1'b0;
    check($sformatf("%s/valid", tag), 12'(out_valid[k]), 12'd1);
    check($sformatf("%s/ready_out", tag), 12'(in_ready[k]), 12'd0);
    check($sformatf("%s/result", tag), outp[k], ef);
    for (int i = 0; i < hold; i++) begin
      tick();
      check($sformatf("%s/held_valid", tag), 12'(out_valid[k]), 12'd1);
      check($sformatf("%s/held_result", tag), outp[k], ef);
    end
    out_ready[k] = 1'b1;
    tick();
    check($sformatf("%s/drained_valid", tag), 12'(out_valid[k]), 12'd0);
    check($sformatf("%s/drained_ready", tag), 12'(in_ready[k]), 12'd1);
    check($sformatf("%s/cleared", tag), outp[k], 12'd0);
  endtask

  initial begin
    logic [11:0] e;
    rst = 1'b1;
    w_we = 2'b00; w_row = 2'b00; w_col = 2'b00; w_data = '0;
    in_valid = 2'b00; in_data = '0; out_ready = 2'b11;
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++) wm[k][r][c] = 0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("reset/outp", outp[k], 12'd0);
      check("reset/out_valid", 12'(out_valid[k]), 12'd0);
      check("reset/in_ready", 12'(in_ready[k]), 12'd1);
    end
    @(negedge clk);
    rst = 1'b0;

    // Basic unsigned example and operand extremes.
    load(0, 2'd1, 2'd2, 2'd3, 2'd3);
    run_vec(0, 2'd3, 2'd1, 0, 0, "basic");
    load(0, 2'd3, 2'd3, 2'd3, 2'd3);
    run_vec(0, 2'd3, 2'd3, 0, 0, "max");
    run_vec(0, 2'd0, 2'd0, 0, 0, "zero");

    // Signed instance.
    load(1, 2'b10, 2'b10, 2'b10, 2'b10);
    run_vec(1, 2'b10, 2'b10, 0, 0, "sneg");
    load(1, 2'b01, 2'b10, 2'b10, 2'b01);
    run_vec(1, 2'b01, 2'b01, 0, 0, "smix");

    // Backpressure with in_valid held high throughout the hold-off.
    load(0, 2'd1, 2'd2, 2'd3, 2'd3);
    out_ready[0] = 1'b0;
    in_valid[0] = 1'b1; in_data[0] = 2'd2;
    tick();
    in_data[0] = 2'd1;
    e = expect_out(0, 2'd2, 2'd1, 2);
    tick();
    in_data[0] = 2'd3;
    check("bp/first", outp[0], e);
    repeat (5) begin
      tick();
      check("bp/valid", 12'(out_valid[0]), 12'd1);
      check("bp/ready", 12'(in_ready[0]), 12'd0);
      check("bp/outp", outp[0], e);
    end
    out_ready[0] = 1'b1;
    tick();
    check("bp/drain_clear", outp[0], 12'd0);
    check("bp/drain_ready", 12'(in_ready[0]), 12'd1);
    tick();
    in_valid[0] = 1'b0;
    e = expect_out(0, 2'd3, 2'd0, 1);
    check("bp/next_col0", outp[0], e);
    check("bp/next_valid", 12'(out_valid[0]), 12'd0);
    in_valid[0] = 1'b1; in_data[0] = 2'd0;
    tick();
    in_valid[0] = 1'b0;
    check("bp/next_result", outp[0], e);
    check("bp/next_out_valid", 12'(out_valid[0]), 12'd1);
    tick();
    check("bp/next_drained", outp[0], 12'd0);

    // Reset mid-vector.
    in_valid[0] = 1'b1; in_data[0] = 2'd3;
    tick();
    in_valid[0] = 1'b0;
    check("rstmid/partial", outp[0], expect_out(0, 2'd3, 2'd0, 1));
    #2 rst = 1'b1;
    #1;
    check("rstmid/outp", outp[0], 12'd0);
    check("rstmid/out_valid", 12'(out_valid[0]), 12'd0);
    check("rstmid/in_ready", 12'(in_ready[0]), 12'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++) wm[k][r][c] = 0;
    run_vec(0, 2'd3, 2'd3, 0, 0, "wclr_u");
    run_vec(1, 2'(3'($urandom_range(0, 3))), 2'(3'($urandom_range(0, 3))), 0, 0, "wclr_s");
    load(0, 2'd1, 2'd2, 2'd3, 2'd3);
    run_vec(0, 2'd2, 2'd1, 0, 0, "after_rst");

    // Weight rewrite in the same cycle column 1 is accepted.
    e = expect_out(0, 2'd1, 2'd2, 2);
    in_valid[0] = 1'b1; in_data[0] = 2'd1;
    tick();
    in_data[0] = 2'd2;
    w_we[0] = 1'b1; w_row[0] = 1'b0; w_col[0] = 1'b1; w_data[0] = 2'd3;
    tick();
    in_valid[0] = 1'b0; w_we[0] = 1'b0;
    wm[0][0][1] = 3;
    check("wrace/result", outp[0], e);
    check("wrace/valid", 12'(out_valid[0]), 12'd1);
    tick();
    check("wrace/cleared", outp[0], 12'd0);
    run_vec(0, 2'd1, 2'd2, 0, 0, "wrace_next");

    // Random traffic on both instances.
    for (int it = 0; it < 24; it++) begin
      for (int k = 0; k < 2; k++) begin
        repeat ($urandom_range(0, 2))
          write_w(k, $urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)));
        run_vec(k, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                $urandom_range(0, 2), $urandom_range(0, 3), $sformatf("rand%0d_%0d", k, it));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
